// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state enum and baud timing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

    localparam int unsigned CLK_FREQ_DEFAULT = 25_000_000;
    localparam int unsigned BAUD_DEFAULT     = 115_200;

    // Rounded clocks-per-bit, so odd ratios land on the nearest integer.
    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ_DEFAULT, BAUD_DEFAULT);
    localparam int unsigned HALF     = BAUD_DIV / 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with synchronous clear; flags the mid-bit and last-clock-of-bit counts.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned DIV = BAUD_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic mid_tick_o,
    output logic full_tick_o
);

    localparam int unsigned CntW = $clog2(DIV);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign mid_tick_o  = (cnt_q == CntW'(DIV / 2 - 1));
    assign full_tick_o = (cnt_q == CntW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || full_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_led_rx.sv
// UART 8N1 receiver that drives each correctly framed byte onto the LED bank.
module uart_led_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int unsigned BAUD     = BAUD_DEFAULT,
    parameter logic [7:0]  LED_RST  = 8'b0000_0001
) (
    input  logic       ext_clk_25m,
    input  logic       ext_rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] led
);

    localparam int unsigned BaudDiv = calc_baud_div(CLK_FREQ, BAUD);

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        fall_edge;
    logic        timer_clr, mid_tick, full_tick;

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [7:0]  led_q, led_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    // Idle-high line, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall_edge = !rx_sync_q && rx_prev_q;

    // Counter is held at zero in idle and restarts on every state transition.
    assign timer_clr = (state_d != state_q) || (state_q == StIdle);

    uart_bit_timer #(
        .DIV (BaudDiv)
    ) u_bit_timer (
        .clk_i       (ext_clk_25m),
        .rst_ni      (ext_rst_n),
        .clr_i       (timer_clr),
        .mid_tick_o  (mid_tick),
        .full_tick_o (full_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        led_d       = led_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (mid_tick) begin
                    if (!rx_sync_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (full_tick) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (full_tick) begin
                    if (rx_sync_q) begin
                        rx_data_d  = shift_q;
                        led_d      = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q     <= StIdle;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            led_q       <= LED_RST;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            led_q       <= led_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign led       = led_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_led_rx.sv
// Directed bench for uart_led_rx: vector table of frames plus reset, glitch and back-to-back cases.
module tb_uart_led_rx;

    localparam int Bit = 217;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] led;

    int n_checks = 0;
    int n_errors = 0;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_both  = 0;
    int         n_long  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] rx_log[$];

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[5];

    always #20 clk = ~clk;

    uart_led_rx dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .led         (led)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid <= n_valid + 1;
            rx_log.push_back(rx_data);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (rx_valid && frame_err) n_both <= n_both + 1;
        if (rx_valid && prev_valid) n_long <= n_long + 1;
        prev_valid <= rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int period, input logic stop);
        uart_rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            uart_rx = d[b];
            repeat (period) @(negedge clk);
        end
        uart_rx = stop;
        repeat (period) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " led"}, {24'h0, led}, 32'h01);
        check({tag, " rx_data"}, {24'h0, rx_data}, 32'h00);
        check({tag, " busy"}, {31'h0, busy}, 32'h0);
        check({tag, " rx_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, " frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        int v0, f0, base, waited;
        logic [31:0] got;
        logic [7:0]  exp_b2b[3];

        vecs[0] = '{8'hA5, 217, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h55, 210, 1'b1, 1, 0, 8'h55};
        vecs[2] = '{8'h55, 224, 1'b1, 1, 0, 8'h55};
        vecs[3] = '{8'h81, 217, 1'b0, 0, 1, 8'h55};
        vecs[4] = '{8'h42, 217, 1'b1, 1, 0, 8'h42};
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h3C;

        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (10 * Bit) @(negedge clk);
        check("post-reset no valid", n_valid, 0);
        check("post-reset no ferr", n_ferr, 0);
        check("post-reset led", {24'h0, led}, 32'h01);
        check("post-reset busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].period, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (30 * Bit) @(negedge clk);
                uart_rx = 1'b1;
            end
            repeat (100) @(negedge clk);
            check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d ferr count", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
            check($sformatf("vec%0d rx_data", i), {24'h0, rx_data}, {24'h0, vecs[i].exp_led});
            check($sformatf("vec%0d busy", i), {31'h0, busy}, 32'h0);
        end

        // Back-to-back frames with zero idle gap.
        v0   = n_valid;
        base = rx_log.size();
        send_frame(8'h00, Bit, 1'b1);
        send_frame(8'hFF, Bit, 1'b1);
        send_frame(8'h3C, Bit, 1'b1);
        repeat (50) @(negedge clk);
        check("b2b valid count", n_valid - v0, 3);
        for (int k = 0; k < 3; k++) begin
            got = (rx_log.size() > base + k) ? {24'h0, rx_log[base+k]} : 32'hDEAD;
            check($sformatf("b2b byte%0d", k), got, {24'h0, exp_b2b[k]});
        end
        check("b2b led", {24'h0, led}, 32'h3C);

        // Low glitches on an idle line.
        v0 = n_valid;
        f0 = n_ferr;
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch1 busy", {31'h0, busy}, 32'h0);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch50 busy rises", {31'h0, busy}, 32'h1);
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
        waited = 0;
        while (busy && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("glitch50 busy timeout", {31'h0, busy}, 32'h0);
        repeat (300) @(negedge clk);
        check("glitch no valid", n_valid - v0, 0);
        check("glitch no ferr", n_ferr - f0, 0);
        check("glitch led", {24'h0, led}, 32'h3C);

        // Reset during bit 4 of a frame.
        v0 = n_valid;
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (Bit) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            uart_rx = b[0];
            repeat (Bit) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        check("midframe busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe rst");
        rst_n = 1'b1;
        repeat (10 * Bit) @(negedge clk);
        check("midframe no valid", n_valid - v0, 0);
        check("midframe no ferr", n_ferr - f0, 0);
        check("midframe idle", {31'h0, busy}, 32'h0);
        check("midframe led", {24'h0, led}, 32'h01);
        send_frame(8'h0F, Bit, 1'b1);
        repeat (100) @(negedge clk);
        check("after rst valid", n_valid - v0, 1);
        check("after rst led", {24'h0, led}, 32'h0F);
        check("after rst rx_data", {24'h0, rx_data}, 32'h0F);

        check("valid+ferr same cycle", n_both, 0);
        check("valid pulse width", n_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
